instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache; the responder for the fetch stage's cache_in/cache_valid interface.
//  Takes one fetch request per accepted address and returns one instruction word with a one-cycle valid pulse.
//  Misses refill a whole line from the memory side by burst read, then answer the fetch request.
//  Sits between the FETCH stage and the instruction memory / bus bridge.
// PARAMETERS
//  DATA_WIDTH   32   instruction and address width (`DATA_WIDTH from sabit_veriler.vh)
//  LINES        64   number of cache lines (power of 2)
//  LINE_WORDS   4    words per line (power of 2, >=2)
// PORTS
//  clk              in   1           clock; all logic on rising edge
//  reset            in   1           synchronous, active-high reset
//  fetch_req_in     in   1           request strobe; sampled only when cache_ready_out=1
//  fetch_addr_in    in   DATA_WIDTH  byte address of the instruction; bits [1:0] ignored
//  abort_in         in   1           fetch redirected (branch/exception/flush); drop the pending response
//  invalidate_in    in   1           clear every valid bit (fence.i)
//  cache_ready_out  out  1           cache can accept a request this cycle
//  cache_out        out  DATA_WIDTH  instruction word, meaningful only while cache_valid_out=1
//  cache_valid_out  out  1           one-cycle response pulse
//  mem_req_out      out  1           burst read request, held until last beat
//  mem_addr_out     out  DATA_WIDTH  line-aligned burst address
//  mem_rdata_in     in   DATA_WIDTH  burst data word
//  mem_rvalid_in    in   1           beat valid; words arrive in ascending order, LINE_WORDS beats
// BEHAVIOUR
//  Address split: offset=[OFS+1:2], index=[IDX+OFS+1:OFS+2], tag=remaining upper bits.
//    OFS=log2(LINE_WORDS), IDX=log2(LINES); defaults give offset [3:2], index [9:4], tag [31:10].
//  Reset: all outputs 0, all valid bits 0, beat counter 0, state IDLE.
//    cache_ready_out=1 in the first cycle after reset.
//  FSM states:
//    IDLE: ready=1. Accepted request latches addr -> LOOKUP.
//    LOOKUP: ready=0. Hit -> cache_valid_out=1 with the word next cycle, return to IDLE.
//      Miss -> REFILL, mem_req_out=1, mem_addr_out=latched addr with low OFS+2 bits zeroed.
//    REFILL: each mem_rvalid_in writes mem_rdata_in to word[beat] and increments beat.
//      On the last beat: write the tag, set the valid bit, drop mem_req_out next cycle -> RESPOND.
//    RESPOND: cache_valid_out=1 for exactly one cycle with the requested word -> IDLE.
//  Latency: hit = 2 cycles request-to-valid. Miss = 2 + cycles until last beat + 1.
//  Throughput: at most one request per 2 cycles; ready is low in every state except IDLE.
//  abort_in:
//    In LOOKUP or RESPOND: suppress the cache_valid_out pulse, go to IDLE.
//    In REFILL: set a sticky abort flag. The burst still completes, the line is still written and
//      validated (memory protocol is never cut short), and the RESPOND pulse is suppressed.
//  invalidate_in: clears all valid bits at the end of the cycle.
//    If it coincides with a LOOKUP, the lookup is a miss.
//    During REFILL, the refilled line is written but left invalid; the response is still delivered.
//  abort_in and invalidate_in in the same cycle: both apply.
//  A request asserted while ready=0 is ignored; FETCH holds the request until it sees ready.
//  reset mid-refill: mem_req_out=0 next cycle and the beat count is discarded.
//    The memory side must tolerate a dropped burst.
//  Beat counter is OFS bits wide and wraps to 0 on the last beat.
//  mem_rvalid_in outside REFILL is ignored.
// STRUCTURE
//  Package (sabit_veriler.vh): ICACHE_LINES, ICACHE_LINE_WORDS, and the FSM state encodings
//    ICACHE_IDLE, ICACHE_LOOKUP, ICACHE_REFILL, ICACHE_RESPOND.
//  Sub-module instr_cache_array holds the tag array, the data array and the valid bits.
//    Valid bits are flops so they can be cleared in one cycle; tag and data arrays are synchronous-read RAM.
//  Top level holds the FSM, the address/abort latches and the beat counter.
// TESTING
//  1 Cold miss: after reset, req addr 0x00000104.
//    -> mem_addr_out=0x00000100, 4 beats 0xA0..0xA3, cache_out=0xA1 valid for 1 cycle.
//  2 Hit: then req 0x0000010C -> cache_out=0xA3 exactly 2 cycles after accept, mem_req_out stays 0.
//  3 Conflict: req 0x00000504 (same index 0x10, new tag).
//    -> refill from 0x500; a following req 0x104 misses again.
//  4 Abort in REFILL: assert abort_in on beat 1.
//    -> all 4 beats consumed, no cache_valid_out, re-request of the same addr hits.
//  5 Invalidate: after test 2 pulse invalidate_in, req 0x108 -> miss, refill from 0x100.
//  6 Reset mid-refill after 2 beats -> mem_req_out=0 next cycle; req 0x104 afterwards misses.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared sizing constants and FSM state encoding for the instruction cache.
package instr_cache_pkg;

    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_LINES      = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ICACHE_IDLE    = 2'd0,
        ICACHE_LOOKUP  = 2'd1,
        ICACHE_REFILL  = 2'd2,
        ICACHE_RESPOND = 2'd3
    } icache_state_t;

endpackage

// File: rtl/instr_cache_array.sv
// Tag/data storage for the instruction cache. Tags and data are synchronous-read
// RAMs; data is split into one bank per word so a whole line reads in one cycle.
// Valid bits are flops so fence.i can clear them all at once.
module instr_cache_array
    import instr_cache_pkg::*;
#(
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int OFS_W      = $clog2(LINE_WORDS),
    parameter int IDX_W      = $clog2(LINES),
    parameter int TAG_W      = DATA_WIDTH - IDX_W - OFS_W - 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rd_en,
    input  logic [IDX_W-1:0]                 rd_index,
    output logic [TAG_W-1:0]                 rd_tag,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_line,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_index,
    input  logic [OFS_W-1:0]                 wr_offset,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             tag_we,
    input  logic [TAG_W-1:0]                 wr_tag,
    input  logic                             set_valid,
    input  logic                             invalidate,
    output logic [LINES-1:0]                 valid_bits
);

    logic [TAG_W-1:0] tag_mem [LINES];

    // Tag RAM: write on line completion, registered read on request accept.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
        if (rd_en) begin
            rd_tag <= tag_mem[rd_index];
        end
    end

    for (genvar w = 0; w < LINE_WORDS; w++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [LINES];
        logic [DATA_WIDTH-1:0] rd_q;

        // One data bank per word slot; refill writes the bank selected by the beat.
        always_ff @(posedge clk) begin
            if (wr_en && wr_offset == OFS_W'(w)) begin
                mem[wr_index] <= wr_data;
            end
            if (rd_en) begin
                rd_q <= mem[rd_index];
            end
        end

        assign rd_line[w*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

    // Valid bits: invalidate wins over a same-cycle line fill.
    always_ff @(posedge clk) begin
        if (reset || invalidate) begin
            valid_bits <= '0;
        end else if (set_valid) begin
            valid_bits[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between FETCH and instruction memory.
// Holds the control FSM, request address latch, abort/invalidate stickies and
// the refill beat counter; storage lives in instr_cache_array.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req_in,
    input  logic [DATA_WIDTH-1:0] fetch_addr_in,
    input  logic                  abort_in,
    input  logic                  invalidate_in,
    output logic                  cache_ready_out,
    output logic [DATA_WIDTH-1:0] cache_out,
    output logic                  cache_valid_out,
    output logic                  mem_req_out,
    output logic [DATA_WIDTH-1:0] mem_addr_out,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in,
    input  logic                  mem_rvalid_in
);

    localparam int OFS   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = DATA_WIDTH - IDX - OFS - 2;

    icache_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]            addr_q;
    logic [OFS-1:0]                   beat_q;
    logic                             abort_q;
    logic                             inval_q;
    logic [DATA_WIDTH-1:0]            resp_word_q;

    logic [TAG_W-1:0]                 rd_tag;
    logic [LINE_WORDS*DATA_WIDTH-1:0] rd_line;
    logic [LINES-1:0]                 valid_bits;

    logic [OFS-1:0]                   req_ofs;
    logic [IDX-1:0]                   req_idx;
    logic [TAG_W-1:0]                 req_tag;
    logic                             accept;
    logic                             beat_fire;
    logic                             last_beat;
    logic                             hit;
    logic                             unused_addr_lsb;

    assign req_ofs         = addr_q[OFS+1:2];
    assign req_idx         = addr_q[IDX+OFS+1:OFS+2];
    assign req_tag         = addr_q[DATA_WIDTH-1:IDX+OFS+2];
    assign unused_addr_lsb = ^addr_q[1:0];

    assign accept    = (state_q == ICACHE_IDLE) && fetch_req_in;
    assign beat_fire = (state_q == ICACHE_REFILL) && mem_rvalid_in;
    assign last_beat = beat_fire && (beat_q == OFS'(LINE_WORDS - 1));
    // A same-cycle fence.i forces the lookup to miss.
    assign hit       = valid_bits[req_idx] && (rd_tag == req_tag) && !invalidate_in;

    instr_cache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (accept),
        .rd_index   (fetch_addr_in[IDX+OFS+1:OFS+2]),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .wr_en      (beat_fire),
        .wr_index   (req_idx),
        .wr_offset  (beat_q),
        .wr_data    (mem_rdata_in),
        .tag_we     (last_beat),
        .wr_tag     (req_tag),
        .set_valid  (last_beat && !inval_q && !invalidate_in),
        .invalidate (invalidate_in),
        .valid_bits (valid_bits)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ICACHE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and ready.
    always_comb begin
        state_d         = state_q;
        cache_ready_out = 1'b0;
        case (state_q)
            ICACHE_IDLE: begin
                cache_ready_out = 1'b1;
                if (fetch_req_in) begin
                    state_d = ICACHE_LOOKUP;
                end
            end
            ICACHE_LOOKUP: begin
                if (hit || abort_in) begin
                    state_d = ICACHE_IDLE;
                end else begin
                    state_d = ICACHE_REFILL;
                end
            end
            ICACHE_REFILL: begin
                if (last_beat) begin
                    state_d = ICACHE_RESPOND;
                end
            end
            ICACHE_RESPOND: begin
                state_d = ICACHE_IDLE;
            end
            default: begin
                state_d = ICACHE_IDLE;
            end
        endcase
    end

    // Registered outputs, address latch, beat counter and refill stickies.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_out <= 1'b0;
            cache_out       <= '0;
            mem_req_out     <= 1'b0;
            mem_addr_out    <= '0;
            addr_q          <= '0;
            beat_q          <= '0;
            abort_q         <= 1'b0;
            inval_q         <= 1'b0;
            resp_word_q     <= '0;
        end else begin
            cache_valid_out <= 1'b0;
            if (accept) begin
                addr_q <= fetch_addr_in;
            end
            case (state_q)
                ICACHE_LOOKUP: begin
                    if (hit && !abort_in) begin
                        cache_valid_out <= 1'b1;
                        cache_out       <= rd_line[req_ofs*DATA_WIDTH +: DATA_WIDTH];
                    end else if (!hit && !abort_in) begin
                        mem_req_out  <= 1'b1;
                        mem_addr_out <= {addr_q[DATA_WIDTH-1:OFS+2], {(OFS+2){1'b0}}};
                        beat_q       <= '0;
                        abort_q      <= 1'b0;
                        inval_q      <= 1'b0;
                    end
                end
                ICACHE_REFILL: begin
                    if (abort_in) begin
                        abort_q <= 1'b1;
                    end
                    if (invalidate_in) begin
                        inval_q <= 1'b1;
                    end
                    if (mem_rvalid_in) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == req_ofs) begin
                            resp_word_q <= mem_rdata_in;
                        end
                    end
                    if (last_beat) begin
                        mem_req_out <= 1'b0;
                    end
                end
                ICACHE_RESPOND: begin
                    if (!abort_q && !abort_in) begin
                        cache_valid_out <= 1'b1;
                        cache_out       <= resp_word_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed scoreboard bench for instr_cache: stimulus pushes expected words,
// a negedge monitor pops and compares on every cache_valid_out pulse.
module tb_instr_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req_in = 1'b0;
    logic [31:0] fetch_addr_in = '0;
    logic        abort_in = 1'b0;
    logic        invalidate_in = 1'b0;
    logic        cache_ready_out;
    logic [31:0] cache_out;
    logic        cache_valid_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_rdata_in = '0;
    logic        mem_rvalid_in = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          resp_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    instr_cache dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req_in    (fetch_req_in),
        .fetch_addr_in   (fetch_addr_in),
        .abort_in        (abort_in),
        .invalidate_in   (invalidate_in),
        .cache_ready_out (cache_ready_out),
        .cache_out       (cache_out),
        .cache_valid_out (cache_valid_out),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_rdata_in    (mem_rdata_in),
        .mem_rvalid_in   (mem_rvalid_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && cache_valid_out) begin
            resp_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=%h expected=no_response", cache_out);
            end else begin
                exp_word = exp_q.pop_front();
                if (cache_out !== exp_word) begin
                    failures++;
                    $display("FAIL resp_word actual=%h expected=%h", cache_out, exp_word);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr);
        int n = 0;
        while (!cache_ready_out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", cache_ready_out, 1);
        fetch_req_in  = 1'b1;
        fetch_addr_in = addr;
        @(posedge clk); #1;
        fetch_req_in  = 1'b0;
    endtask

    // Drives a whole burst; optional abort/invalidate on a beat, or reset before a beat.
    task automatic refill(input logic [31:0] line, input logic [31:0] base,
                          input int abort_beat, input int inval_beat, input int reset_beat);
        @(posedge clk); #1;
        chk("mem_req_rise", mem_req_out, 1);
        chk("mem_addr", mem_addr_out, line);
        for (int b = 0; b < 4; b++) begin
            if (b == reset_beat) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("mem_req_after_reset", mem_req_out, 0);
                chk("ready_after_reset", cache_ready_out, 1);
                return;
            end
            mem_rvalid_in = 1'b1;
            mem_rdata_in  = base + b;
            abort_in      = (b == abort_beat);
            invalidate_in = (b == inval_beat);
            @(posedge clk); #1;
            mem_rvalid_in = 1'b0;
            abort_in      = 1'b0;
            invalidate_in = 1'b0;
            if (b < 3) chk("mem_req_held", mem_req_out, 1);
        end
        chk("mem_req_drop", mem_req_out, 0);
        @(posedge clk); #1;
    endtask

    task automatic miss(input logic [31:0] addr, input logic [31:0] line, input logic [31:0] base,
                        input logic expect_resp, input logic [31:0] exp,
                        input int abort_beat, input int inval_beat, input int reset_beat);
        if (expect_resp) exp_q.push_back(exp);
        issue(addr);
        refill(line, base, abort_beat, inval_beat, reset_beat);
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue(addr);
        @(posedge clk); #1;
        chk("hit_latency_valid", cache_valid_out, 1);
        chk("hit_no_mem_req", mem_req_out, 0);
    endtask

    task automatic chk_resp(input int n);
        @(negedge clk); #1;
        chk("resp_count", resp_count, n);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_ready", cache_ready_out, 1);
        chk("reset_valid", cache_valid_out, 0);
        chk("reset_mem_req", mem_req_out, 0);
        chk("reset_mem_addr", mem_addr_out, 0);
        chk("reset_cache_out", cache_out, 0);

        // Cold miss
        miss(32'h104, 32'h100, 32'hA0, 1'b1, 32'hA1, -1, -1, -1);
        chk_resp(1);

        // Stray beat while idle must be ignored
        mem_rvalid_in = 1'b1;
        mem_rdata_in  = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_rvalid_in = 1'b0;

        // Hit
        hit(32'h10C, 32'hA3);
        chk_resp(2);

        // Abort during LOOKUP on a hit: no pulse
        issue(32'h10C);
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        chk("abort_lookup_no_valid", cache_valid_out, 0);
        chk("abort_lookup_idle", cache_ready_out, 1);
        chk_resp(2);

        // Invalidate then same line misses
        invalidate_in = 1'b1;
        @(posedge clk); #1;
        invalidate_in = 1'b0;
        miss(32'h108, 32'h100, 32'hC0, 1'b1, 32'hC2, -1, -1, -1);
        chk_resp(3);

        // Conflict at index 0x10
        miss(32'h504, 32'h500, 32'hB0, 1'b1, 32'hB1, -1, -1, -1);
        miss(32'h104, 32'h100, 32'hA0, 1'b1, 32'hA1, -1, -1, -1);
        chk_resp(5);

        // Abort during REFILL on beat 1: no response, line still valid
        miss(32'h208, 32'h200, 32'hF0, 1'b0, 32'h0, 1, -1, -1);
        chk_resp(5);
        hit(32'h208, 32'hF2);
        chk_resp(6);

        // Invalidate during REFILL: response delivered, line left invalid
        miss(32'h304, 32'h300, 32'h60, 1'b1, 32'h61, -1, 2, -1);
        chk_resp(7);
        miss(32'h304, 32'h300, 32'h70, 1'b1, 32'h71, -1, -1, -1);
        chk_resp(8);

        // Reset after two beats, then a previously cached line misses
        miss(32'h404, 32'h400, 32'hD0, 1'b0, 32'h0, -1, -1, 2);
        miss(32'h104, 32'h100, 32'hE0, 1'b1, 32'hE1, -1, -1, -1);
        chk_resp(9);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
